// File: rtl/ttt_move_engine.sv
// Tic-tac-toe computer-move generator: snapshots the board on start and scans for a
// win, block, centre, then first free cell. Optional macro MOVE_ENGINE_LFSR_EN randomises
// the FILL start cell.
module ttt_move_engine #(
    parameter int unsigned PC_PULSE_CYCLES = 1,
    parameter bit          BLOCK_EN        = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [17:0] board,
    output logic        pc,
    output logic [3:0]  computer_position,
    output logic [1:0]  move_src,
    output logic        busy,
    output logic        no_move
);

    typedef enum logic [2:0] {
        StIdle, StWin, StBlock, StCenter, StFill, StEmit, StNomove
    } state_e;

    state_e      state_q, state_d;
    logic [17:0] snap_q, snap_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  pos_q, pos_d;
    logic [1:0]  src_q, src_d;
    logic        pc_q, pc_d;
    logic        busy_q, busy_d;
    logic        nm_q, nm_d;
    logic [3:0]  fill_off;

`ifdef MOVE_ENGINE_LFSR_EN
    logic [3:0] lfsr_q, lfsr_d;
    logic [3:0] off_q, off_d;

    always_comb begin
        lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
        off_d  = off_q;
        if (state_q == StIdle && start) begin
            off_d = (lfsr_q < 4'd9) ? lfsr_q : lfsr_q - 4'd9;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q <= 4'b1001;
            off_q  <= 4'd0;
        end else begin
            lfsr_q <= lfsr_d;
            off_q  <= off_d;
        end
    end

    assign fill_off = off_q;
`else
    assign fill_off = 4'd0;
`endif

    // Cells of the line currently under test.
    logic [3:0] c0, c1, c2;
    always_comb begin
        c0 = 4'd0;
        c1 = 4'd1;
        c2 = 4'd2;
        unique case (cnt_q[2:0])
            3'd0: begin c0 = 4'd0; c1 = 4'd1; c2 = 4'd2; end
            3'd1: begin c0 = 4'd3; c1 = 4'd4; c2 = 4'd5; end
            3'd2: begin c0 = 4'd6; c1 = 4'd7; c2 = 4'd8; end
            3'd3: begin c0 = 4'd0; c1 = 4'd3; c2 = 4'd6; end
            3'd4: begin c0 = 4'd1; c1 = 4'd4; c2 = 4'd7; end
            3'd5: begin c0 = 4'd2; c1 = 4'd5; c2 = 4'd8; end
            3'd6: begin c0 = 4'd0; c1 = 4'd4; c2 = 4'd8; end
            3'd7: begin c0 = 4'd2; c1 = 4'd4; c2 = 4'd6; end
            default: ;
        endcase
    end

    logic [1:0] v0, v1, v2, code, probe_v;
    logic       line_hit;
    logic [3:0] line_tgt, probe;
    logic [4:0] probe_sum;

    always_comb begin
        v0       = snap_q[{c0, 1'b0} +: 2];
        v1       = snap_q[{c1, 1'b0} +: 2];
        v2       = snap_q[{c2, 1'b0} +: 2];
        code     = (state_q == StWin) ? 2'b10 : 2'b01;
        line_hit = 1'b1;
        line_tgt = c0;
        if (v0 == 2'b00 && v1 == code && v2 == code) begin
            line_tgt = c0;
        end else if (v1 == 2'b00 && v0 == code && v2 == code) begin
            line_tgt = c1;
        end else if (v2 == 2'b00 && v0 == code && v1 == code) begin
            line_tgt = c2;
        end else begin
            line_hit = 1'b0;
        end
        // Offset plus probe count never exceeds 16, so one subtraction wraps mod 9.
        probe_sum = {1'b0, fill_off} + {1'b0, cnt_q};
        probe     = (probe_sum >= 5'd9) ? 4'(probe_sum - 5'd9) : probe_sum[3:0];
        probe_v   = snap_q[{probe, 1'b0} +: 2];
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        src_d   = src_q;
        pc_d    = 1'b0;
        nm_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    snap_d  = board;
                    cnt_d   = 4'd0;
                    state_d = StWin;
                end
            end
            StWin, StBlock: begin
                if (line_hit) begin
                    pos_d   = line_tgt;
                    src_d   = (state_q == StWin) ? 2'b00 : 2'b01;
                    pc_d    = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = StEmit;
                end else if (cnt_q == 4'd7) begin
                    cnt_d   = 4'd0;
                    state_d = (state_q == StWin && BLOCK_EN) ? StBlock : StCenter;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StCenter: begin
                cnt_d = 4'd0;
                if (snap_q[9:8] == 2'b00) begin
                    pos_d   = 4'd4;
                    src_d   = 2'b10;
                    pc_d    = 1'b1;
                    state_d = StEmit;
                end else begin
                    state_d = StFill;
                end
            end
            StFill: begin
                if (probe_v == 2'b00) begin
                    pos_d   = probe;
                    src_d   = 2'b11;
                    pc_d    = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = StEmit;
                end else if (cnt_q == 4'd8) begin
                    cnt_d   = 4'd0;
                    state_d = StNomove;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StEmit: begin
                if (cnt_q == 4'(PC_PULSE_CYCLES - 1)) begin
                    cnt_d   = 4'd0;
                    state_d = StIdle;
                end else begin
                    pc_d  = 1'b1;
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StNomove: begin
                nm_d    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            snap_q  <= 18'd0;
            cnt_q   <= 4'd0;
            pos_q   <= 4'd0;
            src_q   <= 2'b00;
            pc_q    <= 1'b0;
            busy_q  <= 1'b0;
            nm_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            src_q   <= src_d;
            pc_q    <= pc_d;
            busy_q  <= busy_d;
            nm_q    <= nm_d;
        end
    end

    assign pc                = pc_q;
    assign computer_position = pos_q;
    assign move_src          = src_q;
    assign busy              = busy_q;
    assign no_move           = nm_q;

endmodule

// File: tb/tb_ttt_move_engine.sv
// Scoreboard bench for ttt_move_engine: two instances (defaults, and 3-cycle pc without
// BLOCK) share stimulus; a monitor pops expected moves whenever pc or no_move rises.
module tb_ttt_move_engine;

    localparam logic [1:0] E = 2'b00;
    localparam logic [1:0] P = 2'b01;
    localparam logic [1:0] C = 2'b10;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [17:0] board = 18'd0;

    logic       pc0, pc1, busy0, busy1, nm0, nm1;
    logic [3:0] pos0, pos1;
    logic [1:0] src0, src1;

    ttt_move_engine #(.PC_PULSE_CYCLES(1), .BLOCK_EN(1'b1)) dut0 (
        .clock(clock), .reset(reset), .start(start), .board(board), .pc(pc0),
        .computer_position(pos0), .move_src(src0), .busy(busy0), .no_move(nm0)
    );
    ttt_move_engine #(.PC_PULSE_CYCLES(3), .BLOCK_EN(1'b0)) dut1 (
        .clock(clock), .reset(reset), .start(start), .board(board), .pc(pc1),
        .computer_position(pos1), .move_src(src1), .busy(busy1), .no_move(nm1)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    int e0  = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit nm;
        int pos;
        int src;
        int lat;
        int width;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic note_fail(input string nm, input int act, input int exp);
        n_chk++;
        $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic push(input int d, input bit nm, input int pos, input int src,
                        input int lat, input int width);
        exp_t e;
        e.nm = nm; e.pos = pos; e.src = src; e.lat = lat; e.width = width;
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    function automatic logic [17:0] bd(input logic [1:0] a0, a1, a2, a3, a4, a5, a6, a7, a8);
        return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
    endfunction

    // First empty cell scanning from off, and its probe number.
    function automatic void pick(input logic [17:0] b, input int off, output int p,
                                 output int k);
        p = 0;
        k = 9;
        for (int i = 0; i < 9; i++) begin
            int c = (off + i) % 9;
            if (k == 9 && b[2*c +: 2] == 2'b00) begin
                p = c;
                k = i;
            end
        end
    endfunction

`ifdef MOVE_ENGINE_LFSR_EN
    logic [3:0] lfsr_m;
    always @(posedge clock or posedge reset) begin
        if (reset) lfsr_m <= 4'b1001;
        else lfsr_m <= {lfsr_m[2:0], lfsr_m[3] ^ lfsr_m[2]};
    end
    function automatic int model_off();
        return (lfsr_m < 4'd9) ? int'(lfsr_m) : int'(lfsr_m) - 9;
    endfunction
`endif

    // Monitor
    logic pc_p[2];
    logic nm_p[2];
    int   wcnt[2];
    int   wexp[2];
    initial begin
        pc_p[0] = 0; pc_p[1] = 0; nm_p[0] = 0; nm_p[1] = 0;
        wcnt[0] = 0; wcnt[1] = 0; wexp[0] = 0; wexp[1] = 0;
    end

    always @(negedge clock) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                logic pcv, nmv;
                int   posv, srcv;
                exp_t e;
                pcv  = (d == 0) ? pc0 : pc1;
                nmv  = (d == 0) ? nm0 : nm1;
                posv = int'((d == 0) ? pos0 : pos1);
                srcv = int'((d == 0) ? src0 : src1);
                if ((pcv && !pc_p[d]) || (nmv && !nm_p[d])) begin
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        note_fail($sformatf("spurious_output dut%0d pc", d), int'(pcv), 0);
                    end else begin
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("kind_no_move dut%0d", d), int'(nmv), int'(e.nm));
                        chk($sformatf("position dut%0d", d), posv, e.pos);
                        chk($sformatf("move_src dut%0d", d), srcv, e.src);
                        chk($sformatf("latency dut%0d", d), cyc - e0, e.lat);
                        wcnt[d] = 1;
                        wexp[d] = e.width;
                    end
                end else if (pcv) begin
                    wcnt[d]++;
                end
                if (!pcv && pc_p[d]) chk($sformatf("pc_width dut%0d", d), wcnt[d], wexp[d]);
                if (nmv && nm_p[d]) note_fail($sformatf("no_move_width dut%0d", d), 2, 1);
                pc_p[d] = pcv;
                nm_p[d] = nmv;
            end
        end
    end

    task automatic issue(input logic [17:0] b);
        @(negedge clock);
        board = b;
        start = 1'b1;
        @(posedge clock);
        #1;
        e0    = cyc;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        bit done = 0;
        for (int i = 0; i < 80 && !done; i++) begin
            @(negedge clock);
            if (!busy0 && !busy1 && q0.size() == 0 && q1.size() == 0) done = 1;
        end
        if (!done) note_fail({"timeout ", nm}, q0.size() + q1.size(), 0);
        repeat (2) @(negedge clock);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " pc0"}, int'(pc0), 0);
        chk({tag, " busy0"}, int'(busy0), 0);
        chk({tag, " no_move0"}, int'(nm0), 0);
        chk({tag, " pos0"}, int'(pos0), 0);
        chk({tag, " src0"}, int'(src0), 0);
        chk({tag, " pc1"}, int'(pc1), 0);
        chk({tag, " busy1"}, int'(busy1), 0);
        chk({tag, " pos1"}, int'(pos1), 0);
    endtask

    initial begin
        logic [17:0] b;
        int p, k, p1;
        #1;
        chk_reset("reset");
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Win on L0 -> cell 2
        b = bd(C, C, E, P, P, E, E, E, E);
        push(0, 0, 2, 0, 1, 1);
        push(1, 0, 2, 0, 1, 3);
        issue(b);
        wait_idle("win_l0");

        // Block on L1 -> cell 5; without BLOCK, fill skips occupied cell 0
        b = bd(C, E, E, P, P, E, E, E, C);
        push(0, 0, 5, 1, 10, 1);
        p1 = 1;
`ifdef MOVE_ENGINE_LFSR_EN
        pick(b, model_off(), p, k);
        p1 = p;
        push(1, 0, p, 3, 10 + k, 3);
`else
        push(1, 0, 1, 3, 11, 3);
`endif
        issue(b);
        wait_idle("block_l1");

        // Full board: no_move, outputs retain previous move
        b = bd(C, P, C, C, P, P, P, C, C);
        push(0, 1, 5, 1, 27, 0);
        push(1, 1, p1, 3, 19, 0);
        issue(b);
        wait_idle("full");

        // Empty board -> centre
        b = 18'd0;
        push(0, 0, 4, 2, 17, 1);
        push(1, 0, 4, 2, 9, 3);
        issue(b);
        wait_idle("centre");

        // Only centre taken -> fill
        b = bd(E, E, E, E, P, E, E, E, E);
`ifdef MOVE_ENGINE_LFSR_EN
        pick(b, model_off(), p, k);
        push(0, 0, p, 3, 18 + k, 1);
        push(1, 0, p, 3, 10 + k, 3);
`else
        push(0, 0, 0, 3, 18, 1);
        push(1, 0, 0, 3, 10, 3);
`endif
        issue(b);
        wait_idle("fill");

        // Win on L7 beats a block on L0
        b = bd(P, P, E, E, C, E, C, E, E);
        push(0, 0, 2, 0, 8, 1);
        push(1, 0, 2, 0, 8, 3);
        issue(b);
        wait_idle("win_l7");

        // Restart at E3 and board change at E5 are ignored
        push(0, 0, 4, 2, 17, 1);
        push(1, 0, 4, 2, 9, 3);
        issue(18'd0);
        repeat (3) @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (2) @(negedge clock);
        board = bd(C, C, E, E, E, E, E, E, E);
        wait_idle("ignored_inputs");

        // Reset at E6 aborts both scans
        issue(18'd0);
        repeat (6) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk_reset("mid_reset");
        @(negedge clock);
        reset = 1'b0;
        pc_p[0] = 0; pc_p[1] = 0; nm_p[0] = 0; nm_p[1] = 0;
        repeat (40) @(negedge clock);
        chk("post_reset busy0", int'(busy0), 0);
        chk("post_reset busy1", int'(busy1), 0);

        chk("leftover dut0", q0.size(), 0);
        chk("leftover dut1", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
